// File: rtl/nanotrade_tick_deframer.sv
// Byte-stream deframer for the NanoTrade core: hunts for a sync byte, assembles a 5-byte tick
// frame, validates its XOR checksum and publishes good ticks as a one-cycle strobe.
module nanotrade_tick_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             tick_valid,
    output logic [15:0]      tick_price,
    output logic [7:0]       tick_volume,
    output logic             err_pulse,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count,
    output logic             in_frame
);

    typedef enum logic [2:0] {
        StHunt,
        StPh,
        StPl,
        StVol,
        StCsum
    } state_e;

    // Timeout fires on the idle edge that would bring the count up to TIMEOUT.
    localparam logic [15:0]      TimeoutLast = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;

    state_e           state_q, state_d;
    logic [7:0]       ph_q, ph_d;
    logic [7:0]       pl_q, pl_d;
    logic [7:0]       vol_q, vol_d;
    logic [15:0]      idle_q, idle_d;
    logic [15:0]      price_q, price_d;
    logic [7:0]       volume_q, volume_d;
    logic             tick_valid_q, tick_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             in_frame_q, in_frame_d;

    logic good_frame;
    logic bad_frame;
    logic timeout;

    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        pl_d          = pl_q;
        vol_d         = vol_q;
        idle_d        = idle_q;
        price_d       = price_q;
        volume_d      = volume_q;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        good_frame    = 1'b0;
        bad_frame     = 1'b0;
        timeout       = (state_q != StHunt) && !byte_valid && (idle_q == TimeoutLast);

        case (state_q)
            StHunt: begin
                if (byte_valid && (byte_in == SYNC_BYTE)) begin
                    state_d = StPh;
                end
            end
            StPh: begin
                if (byte_valid) begin
                    ph_d    = byte_in;
                    state_d = StPl;
                end
            end
            StPl: begin
                if (byte_valid) begin
                    pl_d    = byte_in;
                    state_d = StVol;
                end
            end
            StVol: begin
                if (byte_valid) begin
                    vol_d   = byte_in;
                    state_d = StCsum;
                end
            end
            StCsum: begin
                if (byte_valid) begin
                    state_d = StHunt;
                    if (byte_in == (ph_q ^ pl_q ^ vol_q)) begin
                        good_frame = 1'b1;
                    end else begin
                        bad_frame = 1'b1;
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        // Idle tracking only runs inside a frame; a byte on the deadline cycle wins.
        if (state_q == StHunt) begin
            idle_d = '0;
        end else if (byte_valid) begin
            idle_d = '0;
        end else if (timeout) begin
            idle_d  = '0;
            state_d = StHunt;
        end else begin
            idle_d = idle_q + 16'd1;
        end

        if (good_frame) begin
            price_d  = {ph_q, pl_q};
            volume_d = vol_q;
            if (frame_count_q != CntMax) begin
                frame_count_d = frame_count_q + CNT_W'(1);
            end
        end

        if ((bad_frame || timeout) && (err_count_q != CntMax)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end

        tick_valid_d = good_frame;
        err_pulse_d  = bad_frame || timeout;
        in_frame_d   = (state_d != StHunt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            ph_q          <= '0;
            pl_q          <= '0;
            vol_q         <= '0;
            idle_q        <= '0;
            price_q       <= '0;
            volume_q      <= '0;
            tick_valid_q  <= 1'b0;
            err_pulse_q   <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
            in_frame_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            pl_q          <= pl_d;
            vol_q         <= vol_d;
            idle_q        <= idle_d;
            price_q       <= price_d;
            volume_q      <= volume_d;
            tick_valid_q  <= tick_valid_d;
            err_pulse_q   <= err_pulse_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            in_frame_q    <= in_frame_d;
        end
    end

    assign tick_valid  = tick_valid_q;
    assign tick_price  = price_q;
    assign tick_volume = volume_q;
    assign err_pulse   = err_pulse_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign in_frame    = in_frame_q;

endmodule

// File: tb/tb_nanotrade_tick_deframer.sv
// Directed self-checking bench for nanotrade_tick_deframer: two instances share stimulus, one
// with 8-bit counters and one with 2-bit counters to exercise saturation.
module tb_nanotrade_tick_deframer;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        tick_valid;
    logic [15:0] tick_price;
    logic [7:0]  tick_volume;
    logic        err_pulse;
    logic [7:0]  frame_count;
    logic [7:0]  err_count;
    logic        in_frame;

    logic        s_tick_valid;
    logic [15:0] s_tick_price;
    logic [7:0]  s_tick_volume;
    logic        s_err_pulse;
    logic [1:0]  s_frame_count;
    logic [1:0]  s_err_count;
    logic        s_in_frame;

    int n_checks;
    int n_pass;

    nanotrade_tick_deframer #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (4),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .tick_valid  (tick_valid),
        .tick_price  (tick_price),
        .tick_volume (tick_volume),
        .err_pulse   (err_pulse),
        .frame_count (frame_count),
        .err_count   (err_count),
        .in_frame    (in_frame)
    );

    nanotrade_tick_deframer #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (4),
        .CNT_W     (2)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .tick_valid  (s_tick_valid),
        .tick_price  (s_tick_price),
        .tick_volume (s_tick_volume),
        .err_pulse   (s_err_pulse),
        .frame_count (s_frame_count),
        .err_count   (s_err_count),
        .in_frame    (s_in_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One call == one rising edge; outputs are settled when it returns.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] ph, input logic [7:0] pl, input logic [7:0] vol,
                              input logic [7:0] cs);
        send(8'hA5);
        send(ph);
        send(pl);
        send(vol);
        send(cs);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // Reset held with random traffic
        repeat (3) begin
            @(negedge clk);
            byte_in    = 8'($urandom);
            byte_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rst_tick_valid", 32'(tick_valid), 32'd0);
        check("rst_price", 32'(tick_price), 32'd0);
        check("rst_volume", 32'(tick_volume), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_frame", 32'(in_frame), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst        = 1'b0;
        idle();
        idle();
        check("post_rst_in_frame", 32'(in_frame), 32'd0);
        check("post_rst_frame_count", 32'(frame_count), 32'd0);
        check("post_rst_price", 32'(tick_price), 32'd0);

        // Good frame
        send(8'hA5);
        check("good_in_frame_rise", 32'(in_frame), 32'd1);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        check("good_no_early_tick", 32'(tick_valid), 32'd0);
        send(8'h70);
        check("good_tick_valid", 32'(tick_valid), 32'd1);
        check("good_price", 32'(tick_price), 32'h1234);
        check("good_volume", 32'(tick_volume), 32'h56);
        check("good_frame_count", 32'(frame_count), 32'd1);
        check("good_err_count", 32'(err_count), 32'd0);
        check("good_err_pulse", 32'(err_pulse), 32'd0);
        check("good_in_frame_fall", 32'(in_frame), 32'd0);
        idle();
        check("good_tick_one_cycle", 32'(tick_valid), 32'd0);
        check("good_price_hold", 32'(tick_price), 32'h1234);

        // Bad checksum: prior tick stays published
        send_frame(8'h12, 8'h34, 8'h56, 8'h71);
        check("bad_err_pulse", 32'(err_pulse), 32'd1);
        check("bad_tick_valid", 32'(tick_valid), 32'd0);
        check("bad_err_count", 32'(err_count), 32'd1);
        check("bad_frame_count", 32'(frame_count), 32'd1);
        check("bad_price_hold", 32'(tick_price), 32'h1234);
        idle();
        check("bad_err_one_cycle", 32'(err_pulse), 32'd0);

        // Hunt past junk, sync inside payload is data
        send(8'h00);
        check("hunt_00", 32'(in_frame), 32'd0);
        send(8'hFF);
        check("hunt_ff", 32'(in_frame), 32'd0);
        send(8'hA5);
        send(8'hA5);
        send(8'hA5);
        send(8'h01);
        check("insync_in_frame", 32'(in_frame), 32'd1);
        send(8'h01);
        check("insync_tick_valid", 32'(tick_valid), 32'd1);
        check("insync_price", 32'(tick_price), 32'hA5A5);
        check("insync_volume", 32'(tick_volume), 32'h01);
        check("insync_frame_count", 32'(frame_count), 32'd2);

        // Back-to-back frame straight after a checksum byte
        send_frame(8'h00, 8'h10, 8'h20, 8'h30);
        check("b2b_tick_valid", 32'(tick_valid), 32'd1);
        check("b2b_price", 32'(tick_price), 32'h0010);
        check("b2b_volume", 32'(tick_volume), 32'h20);
        check("b2b_frame_count", 32'(frame_count), 32'd3);

        // Timeout on 4th idle edge
        send(8'hA5);
        send(8'h12);
        idle();
        idle();
        idle();
        check("to_no_early_err", 32'(err_pulse), 32'd0);
        check("to_still_in_frame", 32'(in_frame), 32'd1);
        idle();
        check("to_err_pulse", 32'(err_pulse), 32'd1);
        check("to_in_frame", 32'(in_frame), 32'd0);
        check("to_err_count", 32'(err_count), 32'd2);
        check("to_tick_valid", 32'(tick_valid), 32'd0);
        idle();
        check("to_err_one_cycle", 32'(err_pulse), 32'd0);

        // Byte on the deadline cycle wins
        send(8'hA5);
        send(8'h12);
        idle();
        idle();
        idle();
        send(8'h34);
        check("deadline_no_err", 32'(err_pulse), 32'd0);
        check("deadline_in_frame", 32'(in_frame), 32'd1);
        send(8'h56);
        send(8'h70);
        check("deadline_tick_valid", 32'(tick_valid), 32'd1);
        check("deadline_price", 32'(tick_price), 32'h1234);
        check("deadline_err_count", 32'(err_count), 32'd2);
        send_frame(8'h00, 8'h10, 8'h20, 8'h30);
        check("after_to_tick_valid", 32'(tick_valid), 32'd1);
        check("after_to_price", 32'(tick_price), 32'h0010);
        check("after_to_volume", 32'(tick_volume), 32'h20);
        check("after_to_frame_count", 32'(frame_count), 32'd5);

        // Asynchronous reset mid-frame
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_frame", 32'(in_frame), 32'd0);
        check("arst_frame_count", 32'(frame_count), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_price", 32'(tick_price), 32'd0);
        check("arst_err_pulse", 32'(err_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h56);
        send(8'h70);
        check("arst_trailing_no_tick", 32'(tick_valid), 32'd0);
        check("arst_trailing_no_err", 32'(err_pulse), 32'd0);
        check("arst_trailing_in_frame", 32'(in_frame), 32'd0);
        check("arst_trailing_count", 32'(frame_count), 32'd0);

        // Saturation: 5 good frames on a 2-bit counter
        repeat (5) send_frame(8'h12, 8'h34, 8'h56, 8'h70);
        check("sat_frame_count", 32'(s_frame_count), 32'd3);
        check("sat_wide_frame_count", 32'(frame_count), 32'd5);
        check("sat_tick_valid", 32'(s_tick_valid), 32'd1);
        check("sat_price", 32'(s_tick_price), 32'h1234);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
